// File: rtl/frog_game_ctrl.sv
// Frogger game-flow controller: lives, score, level, per-life countdown timer
// and the dead/win hold windows that gate the frog's movement logic.
module frog_game_ctrl #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int TIME_LIMIT     = 30,
    parameter int HOLD_FRAMES    = 4,
    parameter int START_LIVES    = 3
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [10:0] FrogY,
    input  logic [3:0]  Car_Collision,
    input  logic [3:0]  LPad_Collision,
    output logic        active,
    output logic        dead,
    output logic        win,
    output logic [1:0]  lives,
    output logic [9:0]  score,
    output logic [3:0]  level,
    output logic [5:0]  time_left,
    output logic        game_over
);

    localparam int FCW = $clog2(FRAMES_PER_SEC + 1);
    localparam int HCW = $clog2(HOLD_FRAMES + 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_SEC - 1);
    localparam logic [HCW-1:0] HOLD_LAST  = HCW'(HOLD_FRAMES - 1);
    localparam logic [5:0]     TIME_INIT  = 6'(TIME_LIMIT);
    localparam logic [1:0]     LIVES_INIT = 2'(START_LIVES);
    localparam logic [10:0]    ROW_START  = 11'd440;
    localparam logic [10:0]    RIVER_TOP  = 11'd80;
    localparam logic [10:0]    RIVER_BOT  = 11'd200;
    localparam logic [9:0]     SCORE_MAX  = 10'd999;

    typedef enum logic [2:0] {
        S_IDLE, S_PLAY, S_DYING, S_WIN_HOLD, S_GAME_OVER
    } state_e;

    state_e         state_q, state_d;
    logic           start_q;
    logic [1:0]     lives_q, lives_d;
    logic [9:0]     score_q, score_d;
    logic [3:0]     level_q, level_d;
    logic [5:0]     time_q, time_d;
    logic [FCW-1:0] frame_q, frame_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic [10:0]    row_q, row_d;
    logic           start_rise;
    logic           hazard;

    function automatic logic [9:0] sat_score(input logic [9:0] s, input logic [6:0] inc);
        logic [10:0] sum;
        sum = {1'b0, s} + {4'b0, inc};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[9:0];
    endfunction

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            lives_q <= LIVES_INIT;
            score_q <= '0;
            level_q <= 4'd1;
            time_q  <= TIME_INIT;
            frame_q <= '0;
            hold_q  <= '0;
            row_q   <= ROW_START;
        end else begin
            state_q <= state_d;
            start_q <= start;
            lives_q <= lives_d;
            score_q <= score_d;
            level_q <= level_d;
            time_q  <= time_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        score_d    = score_q;
        level_d    = level_q;
        time_d     = time_q;
        frame_d    = frame_q;
        hold_d     = hold_q;
        row_d      = row_q;
        start_rise = start & ~start_q;
        // Standing in the river band without a lily pad underneath drowns the frog.
        hazard     = (|Car_Collision)
                   || ((FrogY >= RIVER_TOP) && (FrogY <= RIVER_BOT) && (LPad_Collision == 4'd0))
                   || (time_q == 6'd0);

        unique case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_rise) begin
                    lives_d = LIVES_INIT;
                    score_d = '0;
                    level_d = 4'd1;
                    time_d  = TIME_INIT;
                    frame_d = '0;
                    row_d   = ROW_START;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (hazard) begin
                    lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    hold_d  = '0;
                    state_d = S_DYING;
                end else if (FrogY == 11'd0) begin
                    score_d = sat_score(score_q, 7'd10 + {1'b0, time_q});
                    level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                    hold_d  = '0;
                    state_d = S_WIN_HOLD;
                end else begin
                    if (frame_q == FRAME_LAST) begin
                        frame_d = '0;
                        time_d  = (time_q != 6'd0) ? time_q - 6'd1 : 6'd0;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                    // Points only for reaching a row closer to the goal than ever before this life.
                    if (FrogY < row_q) begin
                        score_d = sat_score(score_q, 7'd1);
                        row_d   = FrogY;
                    end
                end
            end
            S_DYING, S_WIN_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    if ((state_q == S_DYING) && (lives_q == 2'd0)) begin
                        state_d = S_GAME_OVER;
                    end else begin
                        time_d  = TIME_INIT;
                        frame_d = '0;
                        row_d   = ROW_START;
                        state_d = S_PLAY;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign active    = (state_q == S_PLAY) || (state_q == S_DYING) || (state_q == S_WIN_HOLD);
    assign dead      = (state_q == S_DYING);
    assign win       = (state_q == S_WIN_HOLD);
    assign game_over = (state_q == S_GAME_OVER);
    assign lives     = lives_q;
    assign score     = score_q;
    assign level     = level_q;
    assign time_left = time_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Bench for frog_game_ctrl: directed scenarios plus random play, all checked
// against a game-rules model that derives the timer from elapsed play cycles.
module tb_frog_game_ctrl;

    localparam int FPS = 60;
    localparam int TL = 30;
    localparam int HOLD = 4;
    localparam int LIVES0 = 3;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] FrogY = 11'd440;
    logic [3:0]  Car_Collision = 4'd0;
    logic [3:0]  LPad_Collision = 4'd0;
    logic        active, dead, win, game_over;
    logic [1:0]  lives;
    logic [9:0]  score;
    logic [3:0]  level;
    logic [5:0]  time_left;
    logic [25:0] dut_vec;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 play, 2 dying, 3 win hold, 4 game over
    int m_mode, m_lives, m_score, m_level, m_play, m_hold, m_best;
    bit m_start_prev;

    frog_game_ctrl #(
        .FRAMES_PER_SEC(FPS), .TIME_LIMIT(TL), .HOLD_FRAMES(HOLD), .START_LIVES(LIVES0)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .start(start), .FrogY(FrogY),
        .Car_Collision(Car_Collision), .LPad_Collision(LPad_Collision),
        .active(active), .dead(dead), .win(win), .lives(lives), .score(score),
        .level(level), .time_left(time_left), .game_over(game_over)
    );

    always #5 frame_clk = ~frame_clk;

    assign dut_vec = {active, dead, win, lives, score, level, time_left, game_over};

    function automatic int m_time();
        int secs;
        secs = m_play / FPS;
        return (secs >= TL) ? 0 : TL - secs;
    endfunction

    function automatic logic [25:0] exp_vec();
        logic a;
        a = (m_mode == 1) || (m_mode == 2) || (m_mode == 3);
        return {a, 1'(m_mode == 2), 1'(m_mode == 3), 2'(m_lives), 10'(m_score),
                4'(m_level), 6'(m_time()), 1'(m_mode == 4)};
    endfunction

    task automatic model_new_life();
        m_play = 0;
        m_best = 440;
    endtask

    task automatic model_step();
        int t;
        bit hz;
        if (Reset) begin
            m_mode = 0; m_lives = LIVES0; m_score = 0; m_level = 1;
            m_hold = 0; m_start_prev = 0;
            model_new_life();
        end else begin
            t = m_time();
            hz = (Car_Collision != 0) || (FrogY >= 80 && FrogY <= 200 && LPad_Collision == 0) || (t == 0);
            case (m_mode)
                0, 4: if (start && !m_start_prev) begin
                    m_lives = LIVES0; m_score = 0; m_level = 1; m_mode = 1;
                    model_new_life();
                end
                1: begin
                    if (hz) begin
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                        m_hold = HOLD; m_mode = 2;
                    end else if (FrogY == 0) begin
                        m_score = (m_score + 10 + t > 999) ? 999 : m_score + 10 + t;
                        m_level = (m_level >= 15) ? 15 : m_level + 1;
                        m_hold = HOLD; m_mode = 3;
                    end else begin
                        m_play++;
                        if (FrogY < m_best) begin
                            m_score = (m_score >= 999) ? 999 : m_score + 1;
                            m_best = FrogY;
                        end
                    end
                end
                default: begin
                    m_hold--;
                    if (m_hold == 0) begin
                        if (m_mode == 2 && m_lives == 0) m_mode = 4;
                        else begin
                            m_mode = 1;
                            model_new_life();
                        end
                    end
                end
            endcase
            m_start_prev = start;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL reset_vec got=%h exp=%h", dut_vec, exp_vec());
        end
        checks++;
        if ({active, dead, win, lives, score, level, time_left, game_over} !== {3'b000, 2'd3, 10'd0, 4'd1, 6'd30, 1'b0}) begin
            failures++; $display("FAIL reset_values got=%h exp=%h", dut_vec, {3'b000, 2'd3, 10'd0, 4'd1, 6'd30, 1'b0});
        end
        tick();
        checks++;
        if (active !== 1'b0) begin
            failures++; $display("FAIL idle_no_start active got=%b exp=0", active);
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({active, lives, time_left, score} !== {1'b1, 2'd3, 6'd30, 10'd0}) begin
            failures++; $display("FAIL start got act=%b lives=%0d time=%0d exp act=1 lives=3 time=30", active, lives, time_left);
        end
    endtask

    task automatic test_timeout();
        int dcnt;
        FrogY = 11'd440; Car_Collision = 4'd0; LPad_Collision = 4'd0;
        repeat (FPS * TL) tick();
        checks++;
        if ({time_left, dead, active} !== {6'd0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL timer_expired got time=%0d dead=%b exp time=0 dead=0", time_left, dead);
        end
        tick();
        checks++;
        if ({dead, lives} !== {1'b1, 2'd2}) begin
            failures++; $display("FAIL timeout_death got dead=%b lives=%0d exp dead=1 lives=2", dead, lives);
        end
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (dead) dcnt++;
            tick();
        end
        checks++;
        if (dcnt != HOLD) begin
            failures++; $display("FAIL dead_width got=%0d exp=%0d", dcnt, HOLD);
        end
        checks++;
        if ({time_left, active, dead} !== {6'd30, 1'b1, 1'b0} || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL after_death got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_priority();
        int s0;
        s0 = m_score;
        Car_Collision = 4'b0010; FrogY = 11'd0;
        tick();
        Car_Collision = 4'd0; FrogY = 11'd440;
        checks++;
        if ({dead, win, lives} !== {1'b1, 1'b0, 2'd1} || score !== 10'(s0)) begin
            failures++; $display("FAIL hazard_over_win got dead=%b win=%b lives=%0d score=%0d exp 1 0 1 %0d", dead, win, lives, score, s0);
        end
        repeat (HOLD) tick();
        checks++;
        if (dut_vec !== exp_vec() || active !== 1'b1 || dead !== 1'b0) begin
            failures++; $display("FAIL priority_recover got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_progress();
        int s0, wcnt, guard;
        int ys[5] = '{440, 400, 360, 400, 360};
        s0 = m_score;
        LPad_Collision = 4'd0;
        foreach (ys[i]) begin
            FrogY = 11'(ys[i]);
            tick();
        end
        checks++;
        if (score !== 10'(s0 + 2)) begin
            failures++; $display("FAIL progress_score got=%0d exp=%0d", score, s0 + 2);
        end
        guard = 0;
        while (m_time() != 25 && guard < 400) begin
            tick();
            guard++;
        end
        checks++;
        if (time_left !== 6'd25) begin
            failures++; $display("FAIL time_25 got=%0d exp=25", time_left);
        end
        FrogY = 11'd0;
        tick();
        FrogY = 11'd440;
        checks++;
        if ({win, dead, level} !== {1'b1, 1'b0, 4'd2} || score !== 10'(s0 + 37)) begin
            failures++; $display("FAIL win_score got win=%b level=%0d score=%0d exp win=1 level=2 score=%0d", win, level, score, s0 + 37);
        end
        wcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (win) wcnt++;
            tick();
        end
        checks++;
        if (wcnt != HOLD) begin
            failures++; $display("FAIL win_width got=%0d exp=%0d", wcnt, HOLD);
        end
        checks++;
        if (dut_vec !== exp_vec() || time_left !== 6'd30) begin
            failures++; $display("FAIL after_win got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_game_over();
        FrogY = 11'd120; LPad_Collision = 4'd0;
        tick();
        FrogY = 11'd440;
        start = 1'b1;
        checks++;
        if ({dead, lives} !== {1'b1, 2'd0}) begin
            failures++; $display("FAIL drown got dead=%b lives=%0d exp dead=1 lives=0", dead, lives);
        end
        repeat (HOLD) tick();
        checks++;
        if ({game_over, active} !== 2'b10) begin
            failures++; $display("FAIL game_over got go=%b act=%b exp go=1 act=0", game_over, active);
        end
        repeat (3) tick();
        start = 1'b0;
        tick();
        checks++;
        if ({game_over, active} !== 2'b10 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL level_start_ignored got=%h exp=%h", dut_vec, exp_vec());
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({active, game_over, score, lives, level} !== {2'b10, 10'd0, 2'd3, 4'd1}) begin
            failures++; $display("FAIL restart got act=%b score=%0d lives=%0d exp act=1 score=0 lives=3", active, score, lives);
        end
    endtask

    task automatic test_saturation();
        int laps, k;
        LPad_Collision = 4'b0001; Car_Collision = 4'd0;
        laps = 0;
        while (m_score < 950 && laps < 10) begin
            for (int y = 439; y >= 1 && m_score < 950; y--) begin
                FrogY = 11'(y);
                tick();
            end
            FrogY = 11'd0;
            tick();
            FrogY = 11'd440;
            repeat (HOLD) tick();
            laps++;
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL climb_laps got=%h exp=%h", dut_vec, exp_vec());
        end
        k = 995 - m_score;
        for (int i = 0; i < k; i++) begin
            FrogY = 11'(439 - i);
            tick();
        end
        checks++;
        if ({score, time_left} !== {10'd995, 6'd30}) begin
            failures++; $display("FAIL pre_sat got score=%0d time=%0d exp score=995 time=30", score, time_left);
        end
        FrogY = 11'd0;
        tick();
        FrogY = 11'd440;
        checks++;
        if ({score, win} !== {10'd999, 1'b1}) begin
            failures++; $display("FAIL score_sat got score=%0d win=%b exp score=999 win=1", score, win);
        end
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if ({win, dead, active, game_over, score} !== {4'b0000, 10'd0} || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL reset_in_win got=%h exp=%h", dut_vec, exp_vec());
        end
        tick();
        checks++;
        if ({win, active} !== 2'b00) begin
            failures++; $display("FAIL no_residual_win got win=%b act=%b exp 0 0", win, active);
        end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 4000; n++) begin
            Reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) start = ~start;
            Car_Collision = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            LPad_Collision = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            r = $urandom_range(0, 99);
            if (r < 3) FrogY = 11'd0;
            else if (r < 60) FrogY = 11'($urandom_range(1, 479));
            else if (FrogY > 11'd10) FrogY = FrogY - 11'($urandom_range(0, 10));
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL random_cycle%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_timeout();
        test_priority();
        test_progress();
        test_game_over();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frog_game_ctrl.md
FROG_GAME_CTRL -- requirements
Module: frog_game_ctrl

Interface
REQ-001 SHALL have parameter FRAMES_PER_SEC, default 60, frames per timer second.
REQ-002 SHALL have parameter TIME_LIMIT, default 30, seconds per life/level.
REQ-003 SHALL have parameter HOLD_FRAMES, default 4, frames dead/win are held.
REQ-004 SHALL have parameter START_LIVES, default 3, lives at game start.
REQ-005 SHALL have port frame_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  start/restart key, level.
REQ-008 SHALL have port FrogY  in  11  frog top Y pixel.
REQ-009 SHALL have port Car_Collision  in  4  per-lane car hit.
REQ-010 SHALL have port LPad_Collision  in  4  per-lane lily pad contact.
REQ-011 SHALL have port active  out  1  frog control enable.
REQ-012 SHALL have port dead  out  1  death indication to frog.
REQ-013 SHALL have port win  out  1  level-complete indication to frog.
REQ-014 SHALL have port lives  out  2  remaining lives.
REQ-015 SHALL have port score  out  10  binary score, 0..999.
REQ-016 SHALL have port level  out  4  current level, 1..15.
REQ-017 SHALL have port time_left  out  6  seconds remaining.
REQ-018 SHALL have port game_over  out  1  high in GAME_OVER.

Function
REQ-019 SHALL implement states IDLE, PLAY, DYING, WIN_HOLD, GAME_OVER.
REQ-020 SHALL register start and define start_rise = start & ~start_q.
REQ-021 SHALL, in IDLE or GAME_OVER on start_rise, load lives=START_LIVES, score=0, level=1, time_left=TIME_LIMIT, frame_cnt=0, best_row=440, and go to PLAY next cycle.
REQ-022 SHALL drive active=1 in PLAY, DYING, WIN_HOLD; 0 in IDLE, GAME_OVER.
REQ-023 SHALL, in PLAY, count frame_cnt 0..FRAMES_PER_SEC-1; at wrap decrement time_left, holding at 0.
REQ-024 SHALL define hazard = |Car_Collision, or (80 <= FrogY <= 200 and LPad_Collision == 0), or time_left == 0.
REQ-025 SHALL, in PLAY, give priority hazard > FrogY==0 (win) > progress in the same cycle.
REQ-026 SHALL, on hazard in PLAY, go to DYING, decrement lives, and clear hold_cnt.
REQ-027 SHALL, on FrogY==0 in PLAY without hazard, go to WIN_HOLD with score += 10 + time_left (saturating at 999) and level += 1 (saturating at 15).
REQ-028 SHALL, in PLAY without hazard or win, and when FrogY < best_row, add 1 to score (saturating) and set best_row = FrogY.
REQ-029 SHALL assert dead=1 for exactly HOLD_FRAMES cycles while in DYING; 0 otherwise.
REQ-030 SHALL assert win=1 for exactly HOLD_FRAMES cycles while in WIN_HOLD; 0 otherwise.
REQ-031 SHALL, at DYING exit, go to GAME_OVER if lives==0, else to PLAY.
REQ-032 SHALL, at DYING exit to PLAY and at WIN_HOLD exit, reload time_left=TIME_LIMIT, frame_cnt=0, best_row=440.
REQ-033 SHALL freeze timer and score in DYING, WIN_HOLD, IDLE, GAME_OVER.
REQ-034 SHALL ignore start outside IDLE/GAME_OVER.
REQ-035 SHALL never underflow lives; a decrement at 0 holds 0.

Reset
REQ-036 SHALL, on Reset=1 at a clock edge, set state=IDLE, active=0, dead=0, win=0, lives=START_LIVES, score=0, level=1, time_left=TIME_LIMIT, frame_cnt=0, hold_cnt=0, best_row=440, start_q=0, game_over=0.
REQ-037 SHALL give Reset priority over all other events, including mid-DYING/WIN_HOLD, with no residual dead/win pulse.

Verification
REQ-038 SHALL be verified by: reset, start pulse -> next cycle PLAY, active=1, lives=3, time_left=30.
REQ-039 SHALL be verified by: PLAY, 60*30 frames with no input -> time_left=0, DYING, dead high 4 cycles, lives=2, time_left=30 after.
REQ-040 SHALL be verified by: Car_Collision=4'b0010 and FrogY=0 in the same cycle -> DYING taken, win stays 0, score unchanged.
REQ-041 SHALL be verified by: FrogY 440->400->360->400->360 -> score +2 only; then FrogY=0 with time_left=25 -> score +35, level=2, win high 4 cycles.
REQ-042 SHALL be verified by: lives=1, FrogY=120, LPad_Collision=0 -> DYING, then GAME_OVER, game_over=1, active=0; start ignored until rising edge, which then restarts with score=0.
REQ-043 SHALL be verified by: score=995 and a win with time_left=30 -> score=999; Reset asserted during WIN_HOLD -> IDLE next cycle, win=0.
